// File: rtl/pwm_generator.sv
// Fixed-period PWM generator. The duty cycle is taken through a valid/ready
// handshake and applied only at a period boundary or when leaving IDLE.
module pwm_generator #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk_3125KHz,
    input  logic             reset,
    input  logic             enable,
    input  logic [CNT_W-1:0] duty_cycle,
    input  logic             duty_valid,
    output logic             duty_ready,
    output logic             pwm_signal,
    output logic             period_done
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        STOP_PEND
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] active_duty;
    logic [CNT_W-1:0] active_duty_nxt;
    logic [CNT_W-1:0] pending_duty;
    logic [CNT_W-1:0] pending_duty_nxt;
    logic             pending_flag;
    logic             pending_flag_nxt;
    logic             at_boundary;
    logic             accept;
    logic             load_duty;
    logic             running_nxt;
    logic             pwm_nxt;
    logic             period_done_nxt;

    // Next-state, counter and duty-transfer decisions
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        load_duty   = 1'b0;
        at_boundary = (state != IDLE) && (cnt == CNT_MAX);

        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (enable) begin
                    state_nxt = RUN;
                    load_duty = pending_flag;
                end
            end
            RUN: begin
                cnt_nxt = cnt + CNT_W'(1);
                if (at_boundary) begin
                    load_duty = pending_flag;
                    if (!enable) state_nxt = IDLE;
                end else if (!enable) begin
                    state_nxt = STOP_PEND;
                end
            end
            STOP_PEND: begin
                cnt_nxt = cnt + CNT_W'(1);
                if (at_boundary) load_duty = pending_flag;
                if (enable) begin
                    state_nxt = RUN;
                end else if (at_boundary) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Duty handshake: a transfer needs pending_flag set, an accept needs it
    // clear, so the two can never happen on the same edge.
    always_comb begin
        accept           = duty_valid && duty_ready;
        pending_flag_nxt = pending_flag;
        pending_duty_nxt = pending_duty;
        active_duty_nxt  = active_duty;
        if (load_duty) begin
            active_duty_nxt  = pending_duty;
            pending_flag_nxt = 1'b0;
        end else if (accept) begin
            pending_duty_nxt = duty_cycle;
            pending_flag_nxt = 1'b1;
        end
    end

    // Outputs are precomputed from next-cycle values so they line up with cnt
    always_comb begin
        running_nxt     = (state_nxt != IDLE);
        pwm_nxt         = running_nxt && (cnt_nxt < active_duty_nxt);
        period_done_nxt = running_nxt && (cnt_nxt == CNT_MAX);
    end

    always_ff @(posedge clk_3125KHz) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            active_duty  <= '0;
            pending_duty <= '0;
            pending_flag <= 1'b0;
            duty_ready   <= 1'b1;
            pwm_signal   <= 1'b0;
            period_done  <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            active_duty  <= active_duty_nxt;
            pending_duty <= pending_duty_nxt;
            pending_flag <= pending_flag_nxt;
            duty_ready   <= !pending_flag_nxt;
            pwm_signal   <= pwm_nxt;
            period_done  <= period_done_nxt;
        end
    end

endmodule

// File: tb/tb_pwm_generator.sv
// Bench for pwm_generator: one expected output record is queued per driven
// cycle and checked by a monitor just after the following rising edge.
module tb_pwm_generator;

    logic       clk_3125KHz = 1'b0;
    logic       reset       = 1'b1;
    logic       enable      = 1'b0;
    logic [3:0] duty_cycle  = 4'd0;
    logic       duty_valid  = 1'b0;
    logic       duty_ready;
    logic       pwm_signal;
    logic       period_done;

    typedef struct packed {
        logic pwm;
        logic pd;
        logic rdy;
    } exp_t;

    typedef struct {
        logic [3:0]  duty;
        logic [15:0] pat;
    } vec_t;

    exp_t  exp_q[$];
    exp_t  cur;
    vec_t  vecs[5];
    int    n_checks = 0;
    int    n_fail   = 0;
    int    step     = 0;
    logic [15:0] pat2, pat4, pat6, pat10;

    always #10 clk_3125KHz = ~clk_3125KHz;

    pwm_generator #(.CNT_W(4)) dut (
        .clk_3125KHz (clk_3125KHz),
        .reset       (reset),
        .enable      (enable),
        .duty_cycle  (duty_cycle),
        .duty_valid  (duty_valid),
        .duty_ready  (duty_ready),
        .pwm_signal  (pwm_signal),
        .period_done (period_done)
    );

    // Monitor: pop the record queued for this edge and compare all outputs
    always @(posedge clk_3125KHz) begin
        #1;
        if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            step++;
            n_checks += 3;
            if (pwm_signal !== cur.pwm) begin
                n_fail++;
                $display("FAIL pwm_signal step %0d: got %b want %b", step, pwm_signal, cur.pwm);
            end
            if (period_done !== cur.pd) begin
                n_fail++;
                $display("FAIL period_done step %0d: got %b want %b", step, period_done, cur.pd);
            end
            if (duty_ready !== cur.rdy) begin
                n_fail++;
                $display("FAIL duty_ready step %0d: got %b want %b", step, duty_ready, cur.rdy);
            end
        end
    end

    task automatic drive(input logic r, input logic e, input logic v, input logic [3:0] d,
                         input logic ep, input logic epd, input logic erdy);
        @(negedge clk_3125KHz);
        reset      = r;
        enable     = e;
        duty_valid = v;
        duty_cycle = d;
        exp_q.push_back('{pwm: ep, pd: epd, rdy: erdy});
    endtask

    initial begin
        pat2  = 16'h0003;
        pat4  = 16'h000F;
        pat6  = 16'h003F;
        pat10 = 16'h03FF;
        vecs[0] = '{duty: 4'd4,  pat: 16'h000F};
        vecs[1] = '{duty: 4'd0,  pat: 16'h0000};
        vecs[2] = '{duty: 4'd15, pat: 16'h7FFF};
        vecs[3] = '{duty: 4'd1,  pat: 16'h0001};
        vecs[4] = '{duty: 4'd10, pat: 16'h03FF};

        // Table: reset, load duty in IDLE, enable, two full periods
        foreach (vecs[i]) begin
            drive(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
            drive(1'b0, 1'b0, 1'b1, vecs[i].duty, 1'b0, 1'b0, 1'b0);
            drive(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
            for (int p = 0; p < 2; p++)
                for (int k = 0; k < 16; k++)
                    drive(1'b0, 1'b1, 1'b0, 4'd0, vecs[i].pat[k], (k == 15), 1'b1);
        end

        // Mid-period update, ignored second offer, boundary-edge offer
        drive(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b1, 4'd4, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 16; k++)
            drive(1'b0, 1'b1, (k == 7) || (k == 9), (k == 7) ? 4'd10 : 4'd12,
                  pat4[k], (k == 15), (k < 7));
        for (int k = 0; k < 16; k++)
            drive(1'b0, 1'b1, 1'b0, 4'd0, pat10[k], (k == 15), 1'b1);
        for (int k = 0; k < 16; k++)
            drive(1'b0, 1'b1, (k == 0), 4'd2, pat10[k], (k == 15), 1'b0);
        for (int k = 0; k < 16; k++)
            drive(1'b0, 1'b1, 1'b0, 4'd0, pat2[k], (k == 15), 1'b1);

        // Stop request mid-period, update while stopping, re-enable in STOP_PEND
        drive(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b1, 4'd4, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 16; k++)
            drive(1'b0, (k < 4), (k == 5), 4'd6, pat4[k], (k == 15), (k < 5));
        for (int i = 0; i < 3; i++)
            drive(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 16; k++)
            drive(1'b0, (k < 4) || (k >= 10), 1'b0, 4'd0, pat6[k], (k == 15), 1'b1);
        for (int k = 0; k < 16; k++)
            drive(1'b0, 1'b1, 1'b0, 4'd0, pat6[k], (k == 15), 1'b1);
        // Enable dropped in the boundary cycle: straight to IDLE
        drive(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);

        // Reset mid-period with pwm high, reset overriding enable and valid
        drive(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b1, 4'd10, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++)
            drive(1'b0, 1'b1, 1'b0, 4'd0, pat10[k], 1'b0, 1'b1);
        drive(1'b1, 1'b1, 1'b1, 4'd5, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 16; k++)
            drive(1'b0, 1'b1, 1'b0, 4'd0, 1'b0, (k == 15), 1'b1);

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 4 && exp_q.size() > 0; i++)
            @(posedge clk_3125KHz);
        #2;
        if (exp_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: got %0d entries left want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
